// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI controller between NREQ requesters.
// Latency: req sampled at edge k -> gnt at k+1, ctrl_en at k+2; ack one cycle after ctrl_busy=0 in DRAIN.
// Backpressure: req is level-held by each requester; the controller stalls us via ctrl_done/ctrl_busy.
// Optional watchdog abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   cfg_cpol,
    input  logic [NREQ-1:0]   cfg_cpha,
    input  logic [4*NREQ-1:0] cfg_len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic              busy,
    output logic              ctrl_en,
    output logic              ctrl_rst,
    output logic              ctrl_cpol,
    output logic              ctrl_cpha,
    output logic [3:0]        ctrl_xfer_len,
    input  logic              ctrl_busy,
    input  logic              ctrl_done,
    input  logic              ctrl_ss,
    output logic [NREQ-1:0]   ss_n
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SPI_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, RESP, ABORT} state_t;
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0]   tmr;
    logic            tmr_hit;
    logic [NREQ-1:0] err_q;
    logic            ctrl_rst_q;
`else
    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, RESP} state_t;
`endif

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   next_ptr;
    logic            found;
    logic [PW:0]     idx;
    logic [NREQ-1:0] win_oh;

    // Search upward from rr_ptr with wrap; first requesting index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    assign win_oh   = NREQ'(1) << winner;
    assign next_ptr = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;

    // Slave select follows the controller only for the granted requester; idle lines stay high.
    assign ss_n = ~(gnt & {NREQ{~ctrl_ss}});

`ifdef SPI_ARB_TIMEOUT_EN
    // The counter lands on TIMEOUT at this edge.
    assign tmr_hit  = (tmr == CW'(TIMEOUT - 1));
    assign err      = err_q;
    assign ctrl_rst = ctrl_rst_q;
`else
    assign err      = '0;
    assign ctrl_rst = 1'b0;
`endif

    // Transaction sequencer; every output is registered and reflects the state entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt           <= '0;
            ack           <= '0;
            busy          <= 1'b0;
            ctrl_en       <= 1'b0;
            ctrl_cpol     <= 1'b0;
            ctrl_cpha     <= 1'b0;
            ctrl_xfer_len <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmr           <= '0;
            err_q         <= '0;
            ctrl_rst_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt           <= win_oh;
                        ctrl_cpol     <= cfg_cpol[winner];
                        ctrl_cpha     <= cfg_cpha[winner];
                        ctrl_xfer_len <= cfg_len[{winner, 2'b00} +: 4];
                        rr_ptr        <= next_ptr;
                        busy          <= 1'b1;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    ctrl_en <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmr     <= '0;
`endif
                    state   <= RUN;
                end
                RUN: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    tmr <= tmr + 1'b1;
                    if (tmr_hit) begin
                        ctrl_en    <= 1'b0;
                        ctrl_rst_q <= 1'b1;
                        tmr        <= '0;
                        state      <= ABORT;
                    end else
`endif
                    if (ctrl_done) begin
                        ctrl_en <= 1'b0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    tmr <= tmr + 1'b1;
                    if (tmr_hit) begin
                        ctrl_rst_q <= 1'b1;
                        tmr        <= '0;
                        state      <= ABORT;
                    end else
`endif
                    if (!ctrl_busy) begin
                        ack   <= gnt;
                        state <= RESP;
                    end
                end
`ifdef SPI_ARB_TIMEOUT_EN
                ABORT: begin
                    // Hold the controller in reset for two cycles, then report.
                    if (tmr[0]) begin
                        ctrl_rst_q <= 1'b0;
                        ack        <= gnt;
                        err_q      <= gnt;
                        state      <= RESP;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
`endif
                RESP: begin
                    ack   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_q <= '0;
`endif
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: random request patterns against a round-robin reference model.
// Latency: checks grant/enable/ack timing relative to sampled edges.
// Backpressure: a behavioural SPI controller model drives ctrl_done/ctrl_busy/ctrl_ss.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, cfg_cpol, cfg_cpha;
    logic [15:0] cfg_len;
    logic [3:0]  gnt, ack, err, ss_n;
    logic        busy, ctrl_en, ctrl_rst, ctrl_cpol, ctrl_cpha;
    logic [3:0]  ctrl_xfer_len;
    logic        ctrl_busy, ctrl_done, ctrl_ss;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    int done_delay = 5;
    int busy_tail  = 1;
    bit never_done = 1'b0;

    spi_arbiter #(.NREQ(4), .TIMEOUT(30)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_len(cfg_len), .gnt(gnt), .ack(ack), .err(err), .busy(busy),
        .ctrl_en(ctrl_en), .ctrl_rst(ctrl_rst), .ctrl_cpol(ctrl_cpol), .ctrl_cpha(ctrl_cpha),
        .ctrl_xfer_len(ctrl_xfer_len), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .ctrl_ss(ctrl_ss), .ss_n(ss_n)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    // Controller model: starts when enabled, pulses done after done_delay cycles, stays busy busy_tail more.
    initial begin
        int cnt;
        bit run;
        int tail;
        cnt = 0; run = 0; tail = 0;
        ctrl_busy = 0; ctrl_done = 0; ctrl_ss = 1;
        forever begin
            @(negedge clk);
            ctrl_done = 0;
            if (!rst_n || ctrl_rst) begin
                run = 0; tail = 0; ctrl_busy = 0; ctrl_ss = 1;
            end else if (run) begin
                cnt++;
                ctrl_ss = 1'($urandom_range(0, 1));
                if (!never_done && cnt >= done_delay) begin
                    ctrl_done = 1; run = 0; tail = busy_tail;
                    if (tail == 0) begin ctrl_busy = 0; ctrl_ss = 1; end
                end
            end else if (tail > 0) begin
                tail--;
                if (tail == 0) begin ctrl_busy = 0; ctrl_ss = 1; end
            end else if (ctrl_en) begin
                run = 1; cnt = 0; ctrl_busy = 1; ctrl_ss = 0;
            end
        end
    end

    // Round-robin rule: first requesting index at or after ptr, wrapping.
    function automatic int model_pick(input logic [3:0] r, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (r[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; req = 0;
        cfg_cpol = 4'hF; cfg_cpha = 4'hF; cfg_len = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gnt !== 0 || ack !== 0 || err !== 0) begin errors++; $display("FAIL reset_gnt_ack_err got %b/%b/%b required 0", gnt, ack, err); end
        checks++; if (busy !== 0 || ctrl_en !== 0 || ctrl_rst !== 0) begin errors++; $display("FAIL reset_busy_en_rst got %b%b%b required 000", busy, ctrl_en, ctrl_rst); end
        checks++; if ({ctrl_cpol, ctrl_cpha, ctrl_xfer_len} !== 6'd0) begin errors++; $display("FAIL reset_mode got %b required 0", {ctrl_cpol, ctrl_cpha, ctrl_xfer_len}); end
        checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL reset_ss_n got %b required 1111", ss_n); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        checks++; if (gnt !== 0 || busy !== 0) begin errors++; $display("FAIL idle_no_req got gnt=%b busy=%b required 0", gnt, busy); end
        m_ptr = 0;
    endtask

    task automatic test_single();
        bit seen;
        logic [3:0] e_ss;
        @(negedge clk);
        cfg_cpol = 4'($urandom); cfg_cpha = 4'($urandom); cfg_len = 16'($urandom);
        cfg_len[7:4] = 4'd7;
        done_delay = 20; busy_tail = 2; req = 4'b0010;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got %b required 0010", gnt); end
        checks++; if (ctrl_xfer_len !== 4'd7) begin errors++; $display("FAIL single_len got %0d required 7", ctrl_xfer_len); end
        checks++; if (ctrl_cpol !== cfg_cpol[1] || ctrl_cpha !== cfg_cpha[1]) begin errors++; $display("FAIL single_mode got %b%b required %b%b", ctrl_cpol, ctrl_cpha, cfg_cpol[1], cfg_cpha[1]); end
        checks++; if (busy !== 1 || ctrl_en !== 0) begin errors++; $display("FAIL single_setup got busy=%b en=%b required 1/0", busy, ctrl_en); end
        @(posedge clk); #1;
        checks++; if (ctrl_en !== 1) begin errors++; $display("FAIL single_en_rise got %b required 1", ctrl_en); end
        seen = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (ctrl_done) begin seen = 1; break; end
            e_ss = 4'b1111; e_ss[1] = ctrl_ss;
            checks++; if (ctrl_en !== 1 || ss_n !== e_ss) begin errors++; $display("FAIL single_run got en=%b ss_n=%b required 1/%b", ctrl_en, ss_n, e_ss); end
        end
        checks++; if (!seen) begin errors++; $display("FAIL single_done_wait got timeout required done"); end
        checks++; if (ctrl_en !== 0) begin errors++; $display("FAIL single_en_fall got %b required 0", ctrl_en); end
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (!ctrl_busy) begin seen = 1; break; end
            checks++; if (ack !== 0) begin errors++; $display("FAIL single_early_ack got %b required 0", ack); end
        end
        checks++; if (!seen || ack !== 4'b0010 || err !== 0) begin errors++; $display("FAIL single_ack got ack=%b err=%b required 0010/0000", ack, err); end
        @(negedge clk); req = 0;
        @(posedge clk); #1;
        checks++; if (ack !== 0 || gnt !== 0 || busy !== 0 || ss_n !== 4'b1111) begin errors++; $display("FAIL single_end got ack=%b gnt=%b busy=%b ss_n=%b required 0/0/0/1111", ack, gnt, busy, ss_n); end
        m_ptr = 2;
    endtask

    // Serve requests until none are pending; each requester drops req during its ack cycle.
    task automatic run_batch(input logic [3:0] pat, input bit add_more);
        int w;
        int guard;
        bit seen;
        logic [3:0] exp_oh;
        logic [5:0] e_mode;
        @(negedge clk); req = pat;
        @(posedge clk); #1;
        guard = 0;
        while (req != 0 && guard < 20) begin
            guard++;
            w = model_pick(req, m_ptr);
            exp_oh = 4'b0001 << w;
            e_mode = {cfg_cpol[w], cfg_cpha[w], cfg_len[4*w +: 4]};
            checks++; if (gnt !== exp_oh) begin errors++; $display("FAIL rr_grant got %b required %b", gnt, exp_oh); end
            checks++; if ({ctrl_cpol, ctrl_cpha, ctrl_xfer_len} !== e_mode) begin errors++; $display("FAIL rr_latch got %b required %b", {ctrl_cpol, ctrl_cpha, ctrl_xfer_len}, e_mode); end
            m_ptr = (w + 1) % 4;
            seen = 0;
            for (int t = 0; t < 400; t++) begin
                @(posedge clk); #1;
                if (t == 1) begin
                    cfg_cpol = 4'($urandom); cfg_cpha = 4'($urandom); cfg_len = 16'($urandom);
                end
                if (ack != 0) begin seen = 1; break; end
                checks++; if ({ctrl_cpol, ctrl_cpha, ctrl_xfer_len} !== e_mode) begin errors++; $display("FAIL cfg_hold got %b required %b", {ctrl_cpol, ctrl_cpha, ctrl_xfer_len}, e_mode); end
            end
            checks++; if (!seen) begin errors++; $display("FAIL ack_wait got timeout required ack"); end
            checks++; if (ack !== exp_oh || err !== 0) begin errors++; $display("FAIL rr_ack got ack=%b err=%b required %b/0000", ack, err, exp_oh); end
            @(negedge clk);
            req[w] = 0;
            if (add_more && guard < 6) req = req | 4'($urandom);
            done_delay = $urandom_range(1, 12);
            busy_tail  = $urandom_range(0, 3);
            @(posedge clk); #1;
            checks++; if (ack !== 0 || gnt !== 0 || busy !== 0) begin errors++; $display("FAIL resp_end got ack=%b gnt=%b busy=%b required 0", ack, gnt, busy); end
            @(posedge clk); #1;
        end
        checks++; if (gnt !== 0 || req !== 0) begin errors++; $display("FAIL batch_idle got gnt=%b req=%b required 0", gnt, req); end
    endtask

    task automatic test_round_robin();
        do_reset();
        done_delay = 3; busy_tail = 1;
        run_batch(4'b1111, 0);
        do_reset();
        run_batch(4'b1001, 0);
    endtask

    task automatic test_cfg_immunity();
        @(negedge clk);
        cfg_cpol[2] = 0; cfg_len[11:8] = 4'd5; done_delay = 8;
        run_batch(4'b0100, 0);
        run_batch(4'b0100, 0);
    endtask

    task automatic test_same_cycle_done();
        done_delay = 1; busy_tail = 0;
        run_batch(4'b1010, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            cfg_cpol = 4'($urandom); cfg_cpha = 4'($urandom); cfg_len = 16'($urandom);
            done_delay = $urandom_range(1, 10); busy_tail = $urandom_range(0, 3);
            run_batch(4'($urandom_range(1, 15)), 1);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk); done_delay = 30; busy_tail = 1; req = 4'b1111;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (ctrl_en) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_en_wait got timeout required ctrl_en"); end
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        checks++; if (gnt !== 0 || ack !== 0 || busy !== 0 || ctrl_en !== 0) begin errors++; $display("FAIL async_rst got gnt=%b ack=%b busy=%b en=%b required 0", gnt, ack, busy, ctrl_en); end
        checks++; if (ss_n !== 4'b1111 || {ctrl_cpol, ctrl_cpha, ctrl_xfer_len} !== 6'd0) begin errors++; $display("FAIL async_rst_ss got ss_n=%b mode=%b required 1111/0", ss_n, {ctrl_cpol, ctrl_cpha, ctrl_xfer_len}); end
        @(posedge clk); #3 rst_n = 1;
        m_ptr = 0;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0001 || busy !== 1) begin errors++; $display("FAIL post_rst_gnt got gnt=%b busy=%b required 0001/1", gnt, busy); end
        m_ptr = 1;
        @(negedge clk); req = 0;
        seen = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (ack != 0) begin seen = 1; break; end
        end
        checks++; if (!seen || ack !== 4'b0001) begin errors++; $display("FAIL post_rst_ack got %b required 0001", ack); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        int rst_cycles;
        logic [3:0] exp_oh;
        @(negedge clk);
        never_done = 1; done_delay = 5; busy_tail = 1; req = 4'b0100;
        exp_oh = 4'b0001 << model_pick(req, m_ptr);
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (ctrl_en) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_en_wait got timeout required ctrl_en"); end
`ifdef SPI_ARB_TIMEOUT_EN
        n = 0; rst_cycles = 0; seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            n++;
            if (ctrl_rst) rst_cycles++;
            if (ack != 0) begin seen = 1; break; end
        end
        checks++; if (!seen || ack !== exp_oh || err !== exp_oh) begin errors++; $display("FAIL to_ack_err got ack=%b err=%b required %b/%b", ack, err, exp_oh, exp_oh); end
        checks++; if (n < 31 || n > 33) begin errors++; $display("FAIL to_latency got %0d required 31..33", n); end
        checks++; if (rst_cycles != 2) begin errors++; $display("FAIL to_ctrl_rst got %0d cycles required 2", rst_cycles); end
        @(negedge clk); req = 0; never_done = 0;
        @(posedge clk); #1;
        checks++; if (busy !== 0 || err !== 0 || ack !== 0) begin errors++; $display("FAIL to_end got busy=%b err=%b ack=%b required 0", busy, err, ack); end
`else
        n = 0; rst_cycles = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            checks++; if (err !== 0 || ctrl_rst !== 0 || ack !== 0) begin errors++; $display("FAIL no_to got err=%b rst=%b ack=%b required 0", err, ctrl_rst, ack); end
        end
        @(negedge clk); never_done = 0;
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (ack != 0) begin seen = 1; break; end
        end
        checks++; if (!seen || ack !== exp_oh || err !== 0) begin errors++; $display("FAIL no_to_ack got ack=%b err=%b required %b/0000", ack, err, exp_oh); end
        @(negedge clk); req = 0;
        @(posedge clk); #1;
        checks++; if (busy !== 0 || n != 0 || rst_cycles != 0) begin errors++; $display("FAIL no_to_end got busy=%b required 0", busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cfg_immunity();
        test_same_cycle_done();
        test_random();
        test_reset_mid_run();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
